// File: rtl/rpn_stack_ctrl_pkg.sv
// ==== calc_pkg : shared types for the RPN calculator controller ====
// ==== rev 1.0 ====
`default_nettype none

package calc_pkg;
  typedef enum logic [1:0] {IDLE, FETCH, EXEC, WRITE} state_t;
  typedef enum logic [1:0] {
    ERR_NONE = 2'b00,
    ERR_OVF  = 2'b01,
    ERR_UNF  = 2'b10,
    ERR_INV  = 2'b11
  } err_t;
  parameter int ALU_OP_W = 2;
endpackage

`default_nettype wire

// File: rtl/rpn_stack_ctrl_if.sv
// ==== rpn_stack_ctrl_if : button/switch, ALU and display signals of the RPN controller ====
// ==== rev 1.0 ====
`default_nettype none

interface rpn_stack_ctrl_if #(
  parameter int BITS  = 16,
  parameter int DEPTH = 4
);
  localparam int DW = $clog2(DEPTH + 1);

  logic [BITS-1:0]              SW;
  logic                         push;
  logic                         drop;
  logic                         exec;
  logic [calc_pkg::ALU_OP_W-1:0] op_sel;
  logic [BITS-1:0]              alu_res;
  logic                         alu_invalid;
  logic [BITS-1:0]              alu_a;
  logic [BITS-1:0]              alu_b;
  logic [calc_pkg::ALU_OP_W-1:0] alu_op;
  logic [BITS-1:0]              top;
  logic [DW-1:0]                depth;
  logic                         busy;
  logic [1:0]                   err;

  modport master (
    output SW, push, drop, exec, op_sel, alu_res, alu_invalid,
    input  alu_a, alu_b, alu_op, top, depth, busy, err
  );

  modport slave (
    input  SW, push, drop, exec, op_sel, alu_res, alu_invalid,
    output alu_a, alu_b, alu_op, top, depth, busy, err
  );
endinterface

`default_nettype wire

// File: rtl/rpn_stack_ctrl_operand_stack.sv
// ==== operand_stack : register-array stack with push, pop and pop-two-write-one ====
// ==== rev 1.0 ====
`default_nettype none

module operand_stack #(
  parameter int BITS  = 16,
  parameter int DEPTH = 4,
  parameter int DW    = $clog2(DEPTH + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic            replace2_i,
  input  logic [BITS-1:0] wr_data_i,
  output logic [BITS-1:0] rd_top_o,
  output logic [BITS-1:0] rd_second_o,
  output logic [DW-1:0]   depth_o,
  output logic            full_o,
  output logic            empty_o
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [BITS-1:0] mem_q [DEPTH];
  logic [DW-1:0]   depth_q, depth_d;
  logic [AW-1:0]   top_idx, sec_idx, push_idx, wr_idx;
  logic            wr_en;

  assign top_idx  = AW'(depth_q - DW'(1));
  assign sec_idx  = AW'(depth_q - DW'(2));
  assign push_idx = AW'(depth_q);

  assign full_o      = (depth_q == DW'(DEPTH));
  assign empty_o     = (depth_q == '0);
  assign depth_o     = depth_q;
  // Slots above depth are stale, so they are masked rather than shown.
  assign rd_top_o    = empty_o ? '0 : mem_q[top_idx];
  assign rd_second_o = (depth_q >= DW'(2)) ? mem_q[sec_idx] : '0;

  always_comb begin
    depth_d = depth_q;
    wr_en   = 1'b0;
    wr_idx  = push_idx;
    if (push_i && !full_o) begin
      wr_en   = 1'b1;
      depth_d = depth_q + DW'(1);
    end else if (pop_i && !empty_o) begin
      depth_d = depth_q - DW'(1);
    end else if (replace2_i && (depth_q >= DW'(2))) begin
      wr_en   = 1'b1;
      wr_idx  = sec_idx;
      depth_d = depth_q - DW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      depth_q <= '0;
    end else begin
      depth_q <= depth_d;
      if (wr_en) mem_q[wr_idx] <= wr_data_i;
    end
  end
endmodule

`default_nettype wire

// File: rtl/rpn_stack_ctrl.sv
// ==== rpn_stack_ctrl : RPN sequencer sharing one combinational ALU via an operand stack ====
// ==== rev 1.0 ====
`default_nettype none

module rpn_stack_ctrl
  import calc_pkg::*;
#(
  parameter int BITS  = 16,
  parameter int DEPTH = 4
) (
  input  logic           CLK100MHZ,
  input  logic           CPU_RESETN,
  rpn_stack_ctrl_if.slave bus
);
  localparam int DW = $clog2(DEPTH + 1);

  state_t              state_q, state_d;
  err_t                err_q, err_d;
  logic [ALU_OP_W-1:0] op_q, op_d;
  logic [ALU_OP_W-1:0] alu_op_q, alu_op_d;
  logic [BITS-1:0]     alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [BITS-1:0]     res_q, res_d;
  logic                inv_q, inv_d;
  logic                stk_push, stk_pop, stk_rep;
  logic [BITS-1:0]     stk_top, stk_second;
  logic [DW-1:0]       stk_depth;
  logic                stk_full, stk_empty;

  operand_stack #(.BITS(BITS), .DEPTH(DEPTH), .DW(DW)) u_stack (
    .clk_i      (CLK100MHZ),
    .rst_ni     (CPU_RESETN),
    .push_i     (stk_push),
    .pop_i      (stk_pop),
    .replace2_i (stk_rep),
    .wr_data_i  (stk_rep ? res_q : bus.SW),
    .rd_top_o   (stk_top),
    .rd_second_o(stk_second),
    .depth_o    (stk_depth),
    .full_o     (stk_full),
    .empty_o    (stk_empty)
  );

  always_comb begin
    state_d  = state_q;
    err_d    = err_q;
    op_d     = op_q;
    alu_a_d  = alu_a_q;
    alu_b_d  = alu_b_q;
    alu_op_d = alu_op_q;
    res_d    = res_q;
    inv_d    = inv_q;
    stk_push = 1'b0;
    stk_pop  = 1'b0;
    stk_rep  = 1'b0;
    unique case (state_q)
      IDLE: begin
        // exec outranks drop, which outranks push
        if (bus.exec) begin
          if (stk_depth < DW'(2)) begin
            err_d = ERR_UNF;
          end else begin
            err_d   = ERR_NONE;
            op_d    = bus.op_sel;
            state_d = FETCH;
          end
        end else if (bus.drop) begin
          err_d   = stk_empty ? ERR_UNF : ERR_NONE;
          stk_pop = !stk_empty;
        end else if (bus.push) begin
          err_d    = stk_full ? ERR_OVF : ERR_NONE;
          stk_push = !stk_full;
        end
      end
      FETCH: begin
        alu_a_d  = stk_second;
        alu_b_d  = stk_top;
        alu_op_d = op_q;
        state_d  = EXEC;
      end
      EXEC: begin
        res_d   = bus.alu_res;
        inv_d   = bus.alu_invalid;
        state_d = WRITE;
      end
      WRITE: begin
        if (inv_q) err_d = ERR_INV;
        else       stk_rep = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK100MHZ) begin
    if (!CPU_RESETN) begin
      state_q  <= IDLE;
      err_q    <= ERR_NONE;
      op_q     <= '0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      alu_op_q <= '0;
      res_q    <= '0;
      inv_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      err_q    <= err_d;
      op_q     <= op_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      alu_op_q <= alu_op_d;
      res_q    <= res_d;
      inv_q    <= inv_d;
    end
  end

  assign bus.alu_a  = alu_a_q;
  assign bus.alu_b  = alu_b_q;
  assign bus.alu_op = alu_op_q;
  assign bus.top    = stk_top;
  assign bus.depth  = stk_depth;
  assign bus.busy   = (state_q != IDLE);
  assign bus.err    = err_q;
endmodule

`default_nettype wire

// File: tb/tb_rpn_stack_ctrl.sv
// ==== tb_rpn_stack_ctrl : scoreboard bench for rpn_stack_ctrl with a list-based stack model ====
// ==== rev 1.0 ====
`default_nettype none

module tb_rpn_stack_ctrl;
  localparam int BITS  = 16;
  localparam int DEPTH = 4;
  localparam int DW    = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [DW-1:0]   depth;
    logic [BITS-1:0] top;
    logic [1:0]      err;
    logic            busy;
    logic [BITS-1:0] a;
    logic [BITS-1:0] b;
    logic [1:0]      op;
  } snap_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  snap_t exp_q[$];

  always #5 clk = ~clk;

  rpn_stack_ctrl_if #(.BITS(BITS), .DEPTH(DEPTH)) bus ();

  rpn_stack_ctrl #(.BITS(BITS), .DEPTH(DEPTH)) dut (
    .CLK100MHZ (clk),
    .CPU_RESETN(rst_n),
    .bus       (bus)
  );

  // Bench ALU: {invalid, result}
  function automatic logic [BITS:0] alu_f(input logic [BITS-1:0] a, input logic [BITS-1:0] b,
                                          input logic [1:0] op);
    logic [BITS-1:0] r;
    case (op)
      2'd0:    begin r = a + b; return {1'b0, r}; end
      2'd1:    begin r = a - b; return {(a < b), r}; end
      2'd2:    begin r = a & b; return {1'b0, r}; end
      default: begin r = a ^ b; return {1'b0, r}; end
    endcase
  endfunction

  assign {bus.alu_invalid, bus.alu_res} = alu_f(bus.alu_a, bus.alu_b, bus.alu_op);

  // Reference model: stack as a list, exec as a countdown of remaining busy cycles
  logic [BITS-1:0] m_stk[$];
  logic [1:0]      m_err = 2'b00;
  int              m_pend = 0;
  logic [1:0]      m_lop = 2'b00;
  logic [BITS-1:0] m_a = '0, m_b = '0, m_res = '0;
  logic [1:0]      m_op = 2'b00;
  logic            m_inv = 1'b0;

  task automatic step(input logic rn, input logic p, input logic d, input logic e,
                      input logic [1:0] op, input logic [BITS-1:0] sw);
    snap_t s;
    logic [BITS-1:0] r;
    @(negedge clk);
    rst_n = rn; bus.push = p; bus.drop = d; bus.exec = e; bus.op_sel = op; bus.SW = sw;
    if (!rn) begin
      m_stk.delete(); m_err = 2'b00; m_pend = 0; m_a = '0; m_b = '0; m_op = 2'b00;
    end else if (m_pend == 0) begin
      if (e) begin
        if (m_stk.size() < 2) m_err = 2'b10;
        else begin m_err = 2'b00; m_lop = op; m_pend = 3; end
      end else if (d) begin
        if (m_stk.size() == 0) m_err = 2'b10;
        else begin m_err = 2'b00; void'(m_stk.pop_back()); end
      end else if (p) begin
        if (m_stk.size() == DEPTH) m_err = 2'b01;
        else begin m_err = 2'b00; m_stk.push_back(sw); end
      end
    end else if (m_pend == 3) begin
      m_a = m_stk[m_stk.size()-2]; m_b = m_stk[m_stk.size()-1]; m_op = m_lop; m_pend = 2;
    end else if (m_pend == 2) begin
      {m_inv, m_res} = alu_f(m_a, m_b, m_op); m_pend = 1;
    end else begin
      if (m_inv) m_err = 2'b11;
      else begin r = m_res; void'(m_stk.pop_back()); void'(m_stk.pop_back()); m_stk.push_back(r); end
      m_pend = 0;
    end
    s.depth = DW'(m_stk.size());
    s.top   = (m_stk.size() > 0) ? m_stk[m_stk.size()-1] : '0;
    s.err   = m_err;
    s.busy  = (m_pend != 0);
    s.a     = m_a;
    s.b     = m_b;
    s.op    = m_op;
    exp_q.push_back(s);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, '0);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: one expected snapshot per accepted clock edge
  initial begin
    snap_t e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("depth", 32'(bus.depth),  32'(e.depth));
        chk("top",   32'(bus.top),    32'(e.top));
        chk("err",   32'(bus.err),    32'(e.err));
        chk("busy",  32'(bus.busy),   32'(e.busy));
        chk("alu_a", 32'(bus.alu_a),  32'(e.a));
        chk("alu_b", 32'(bus.alu_b),  32'(e.b));
        chk("alu_op",32'(bus.alu_op), 32'(e.op));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.push = 1'b0; bus.drop = 1'b0; bus.exec = 1'b0; bus.op_sel = 2'd0; bus.SW = '0;

    // add two operands
    step(1'b0, 0, 0, 0, 2'd0, '0);
    step(1'b0, 0, 0, 0, 2'd0, '0);
    step(1'b1, 1, 0, 0, 2'd0, 16'h0012);
    step(1'b1, 1, 0, 0, 2'd0, 16'h0034);
    step(1'b1, 0, 0, 1, 2'd0, '0);
    idle(4);

    // overflow after the fifth push
    step(1'b0, 0, 0, 0, 2'd0, '0);
    for (int i = 1; i <= 5; i++) step(1'b1, 1, 0, 0, 2'd0, 16'(i));
    idle(1);

    // underflow on empty drop and single-entry exec
    step(1'b0, 0, 0, 0, 2'd0, '0);
    step(1'b1, 0, 1, 0, 2'd0, '0);
    step(1'b1, 1, 0, 0, 2'd0, 16'h0007);
    step(1'b1, 0, 0, 1, 2'd0, '0);
    idle(2);

    // invalid subtraction leaves stack unchanged
    step(1'b0, 0, 0, 0, 2'd0, '0);
    step(1'b1, 1, 0, 0, 2'd0, 16'h0003);
    step(1'b1, 1, 0, 0, 2'd0, 16'h0009);
    step(1'b1, 0, 0, 1, 2'd1, '0);
    idle(4);

    // priority, then commands ignored while busy
    step(1'b0, 0, 0, 0, 2'd0, '0);
    step(1'b1, 1, 0, 0, 2'd0, 16'h0100);
    step(1'b1, 1, 0, 0, 2'd0, 16'h0020);
    step(1'b1, 1, 1, 1, 2'd1, 16'h5555);
    for (int i = 0; i < 3; i++) step(1'b1, 1, 0, 0, 2'd0, 16'hFFFF);
    idle(2);

    // reset in the EXEC cycle aborts the exec
    step(1'b1, 1, 0, 0, 2'd0, 16'h1111);
    step(1'b1, 0, 0, 1, 2'd0, '0);
    step(1'b1, 0, 0, 0, 2'd0, '0);
    step(1'b0, 0, 0, 0, 2'd0, '0);
    idle(2);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic rn, p, d, e;
      logic [15:0] sw;
      rn = ($urandom_range(0, 79) != 0);
      p  = ($urandom_range(0, 1) == 0);
      d  = ($urandom_range(0, 5) == 0);
      e  = ($urandom_range(0, 3) == 0);
      sw = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 15)) : 16'($urandom_range(0, 65535));
      step(rn, p, d, e, 2'($urandom_range(0, 3)), sw);
    end
    idle(4);

    repeat (3) @(posedge clk);
    #3;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

`default_nettype wire
